// File: rtl/ntt_bf_addr_seq_if.sv
// Control and address bundle between the NTT butterfly sequencer
// and the coefficient memory / butterfly datapath.
interface ntt_bf_addr_seq_if #(
  parameter int LOG_N = 8
);
  localparam int SW = $clog2(LOG_N);

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-2:0] rd_tw_idx;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage,
    output rd_en, rd_addr_a, rd_addr_b, rd_tw_idx,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage,
    input  rd_en, rd_addr_a, rd_addr_b, rd_tw_idx,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_bf_addr_seq.sv
// In-place radix-2 NTT butterfly address sequencer: read pairs,
// twiddle indices and write-back pairs delayed by the butterfly latency.
module ntt_bf_addr_seq #(
  parameter int LOG_N  = 8,
  parameter int BF_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  ntt_bf_addr_seq_if.master   bus
);
  localparam int HB = LOG_N - 1;
  localparam int SW = $clog2(LOG_N);
  localparam int DW = $clog2(BF_LAT + 1);
  localparam logic [LOG_N-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             en;
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } wr_t;

  state_t           state;
  logic [SW-1:0]    stage;
  logic [HB-1:0]    bfc;
  logic [DW-1:0]    dcnt;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_a;
  logic [LOG_N-1:0] rd_b;
  logic [HB-1:0]    rd_tw;
  wr_t              pipe [BF_LAT];

  logic [LOG_N-1:0] bx;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] k;
  logic [LOG_N-1:0] lo_a;
  logic [HB-1:0]    tw;

  // group base is bfc with its low stage bits cleared, doubled
  always_comb begin
    bx   = LOG_N'(bfc);
    half = ONE << stage;
    k    = bx & (half - ONE);
    lo_a = ((bx & ~(half - ONE)) << 1) | k;
    tw   = HB'(k << (SW'(LOG_N - 1) - stage));
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      bfc   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_en <= 1'b0;
      rd_a  <= '0;
      rd_b  <= '0;
      rd_tw <= '0;
      for (int i = 0; i < BF_LAT; i++)
        pipe[i] <= '0;
    end else begin
      rd_en <= 1'b0;
      rd_a  <= '0;
      rd_b  <= '0;
      rd_tw <= '0;
      done  <= 1'b0;
      pipe[0] <= {rd_en, rd_a, rd_b};
      for (int i = 1; i < BF_LAT; i++)
        pipe[i] <= pipe[i-1];
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= READ;
            busy  <= 1'b1;
            stage <= '0;
            bfc   <= '0;
          end
        end
        READ: begin
          rd_en <= 1'b1;
          rd_a  <= lo_a;
          rd_b  <= lo_a | half;
          rd_tw <= tw;
          bfc   <= bfc + HB'(1);
          if (bfc == '1) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        // stage barrier: last write of the stage leaves in the final drain cycle
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(BF_LAT - 1)) begin
            if (stage == SW'(LOG_N - 1)) begin
              state <= DONE;
            end else begin
              stage <= stage + SW'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.stage     = stage;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = rd_a;
  assign bus.rd_addr_b = rd_b;
  assign bus.rd_tw_idx = rd_tw;
  assign bus.wr_en     = pipe[BF_LAT-1].en;
  assign bus.wr_addr_a = pipe[BF_LAT-1].a;
  assign bus.wr_addr_b = pipe[BF_LAT-1].b;
endmodule
